// File: rtl/dds_pkg.sv
// Shared opcodes, waveform mode encodings and parser states for the DDS command block.
package dds_pkg;

  localparam logic [7:0] OP_SET_FREQ    = 8'h01;
  localparam logic [7:0] OP_SET_MODE    = 8'h02;
  localparam logic [7:0] OP_SET_DIRECT  = 8'h03;
  localparam logic [7:0] OP_PHASE_RESET = 8'h04;
  localparam logic [7:0] OP_SET_AMP     = 8'h05;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

endpackage

// File: rtl/dds_wave_gen.sv
// Phase accumulator and waveshaper feeding the DAC sample register.
// With DDS_AMPLITUDE_EN defined, an extra stage scales the wave by amp_i (2-cycle latency).
module dds_wave_gen import dds_pkg::*; #(
  parameter int OUT_WIDTH = 6,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_WIDTH-1:0] tw_i,
  input  mode_e                mode_i,
  input  logic [OUT_WIDTH-1:0] direct_i,
`ifdef DDS_AMPLITUDE_EN
  input  logic [7:0]           amp_i,
`endif
  input  logic                 phase_clr_i,
  output logic [OUT_WIDTH-1:0] dds_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH:0]   p;
  logic [OUT_WIDTH-1:0] wave;
  logic [OUT_WIDTH-1:0] dds_q;

  // Phase clear overrides the add on its commit cycle.
  assign acc_d = phase_clr_i ? '0 : acc_q + tw_i;
  assign p     = acc_q[ACC_WIDTH-1 -: OUT_WIDTH+1];

  always_comb begin
    wave = direct_i;
    case (mode_i)
      MODE_SAW:    wave = p[OUT_WIDTH:1];
      MODE_TRI:    wave = p[OUT_WIDTH] ? ~p[OUT_WIDTH-1:0] : p[OUT_WIDTH-1:0];
      MODE_SQUARE: wave = {OUT_WIDTH{acc_q[ACC_WIDTH-1]}};
      default:     wave = direct_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

`ifdef DDS_AMPLITUDE_EN
  logic [OUT_WIDTH-1:0] wave_q;
  logic [OUT_WIDTH+7:0] prod;

  assign prod = wave_q * amp_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q <= '0;
      dds_q  <= '0;
    end else begin
      wave_q <= wave;
      dds_q  <= prod[OUT_WIDTH+7:8];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) dds_q <= '0;
    else     dds_q <= wave;
  end
`endif

  assign dds_o = dds_q;

endmodule

// File: rtl/dds_uart_synth.sv
// Byte-stream command parser with atomic commit and payload timeout, driving dds_wave_gen.
// Optional SET_AMP opcode and amplitude stage enabled by DDS_AMPLITUDE_EN.
module dds_uart_synth import dds_pkg::*; #(
  parameter int OUT_WIDTH      = 6,
  parameter int ACC_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_dv,
  input  logic [7:0]           rx_byte,
  output logic [OUT_WIDTH-1:0] dds_out,
  output logic [1:0]           mode,
  output logic                 busy,
  output logic                 cmd_ok,
  output logic                 cmd_err
);

  localparam int CNT_W = $clog2(ACC_WIDTH/8 + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           op_q, op_d;
  logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [ACC_WIDTH-1:0] tw_q, tw_d;
  mode_e                mode_q, mode_d;
  logic [OUT_WIDTH-1:0] direct_q, direct_d;
  logic                 cmd_ok_q, cmd_ok_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 rx_dv_q;
  logic                 accept;
  logic                 phase_clr;
`ifdef DDS_AMPLITUDE_EN
  logic [7:0]           amp_q, amp_d;
`endif

  assign accept = rx_dv && !rx_dv_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    shadow_d  = shadow_q;
    tmo_d     = '0;
    tw_d      = tw_q;
    mode_d    = mode_q;
    direct_d  = direct_q;
    cmd_ok_d  = 1'b0;
    cmd_err_d = 1'b0;
    phase_clr = 1'b0;
`ifdef DDS_AMPLITUDE_EN
    amp_d     = amp_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = rx_byte;
          shadow_d = '0;
          case (rx_byte)
            OP_SET_FREQ: begin
              state_d = PAYLOAD;
              cnt_d   = CNT_W'(ACC_WIDTH/8);
            end
            OP_SET_MODE, OP_SET_DIRECT: begin
              state_d = PAYLOAD;
              cnt_d   = CNT_W'(1);
            end
`ifdef DDS_AMPLITUDE_EN
            OP_SET_AMP: begin
              state_d = PAYLOAD;
              cnt_d   = CNT_W'(1);
            end
`endif
            OP_PHASE_RESET: begin
              phase_clr = 1'b1;
              cmd_ok_d  = 1'b1;
            end
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      PAYLOAD: begin
        if (accept) begin
          // A byte on the timeout cycle takes priority over the abort.
          shadow_d = (shadow_q << 8) | ACC_WIDTH'(rx_byte);
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            cmd_ok_d = 1'b1;
            case (op_q)
              OP_SET_FREQ:   tw_d     = shadow_d;
              OP_SET_MODE:   mode_d   = mode_e'(rx_byte[1:0]);
              OP_SET_DIRECT: direct_d = rx_byte[7 -: OUT_WIDTH];
`ifdef DDS_AMPLITUDE_EN
              OP_SET_AMP:    amp_d    = rx_byte;
`endif
              default:       ;
            endcase
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          shadow_d  = '0;
          cmd_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      shadow_q  <= '0;
      tmo_q     <= '0;
      tw_q      <= '0;
      mode_q    <= MODE_DIRECT;
      direct_q  <= '0;
      cmd_ok_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      rx_dv_q   <= 1'b0;
`ifdef DDS_AMPLITUDE_EN
      amp_q     <= 8'hFF;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      shadow_q  <= shadow_d;
      tmo_q     <= tmo_d;
      tw_q      <= tw_d;
      mode_q    <= mode_d;
      direct_q  <= direct_d;
      cmd_ok_q  <= cmd_ok_d;
      cmd_err_q <= cmd_err_d;
      rx_dv_q   <= rx_dv;
`ifdef DDS_AMPLITUDE_EN
      amp_q     <= amp_d;
`endif
    end
  end

  dds_wave_gen #(
    .OUT_WIDTH (OUT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_wave (
    .clk         (clk),
    .rst         (rst),
    .tw_i        (tw_q),
    .mode_i      (mode_q),
    .direct_i    (direct_q),
`ifdef DDS_AMPLITUDE_EN
    .amp_i       (amp_q),
`endif
    .phase_clr_i (phase_clr),
    .dds_o       (dds_out)
  );

  assign mode    = mode_q;
  assign busy    = (state_q == PAYLOAD);
  assign cmd_ok  = cmd_ok_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_dds_uart_synth.sv
// Directed bench for dds_uart_synth (default build: 6-bit DAC, 24-bit accumulator, 1200-cycle timeout).
module tb_dds_uart_synth;

  localparam int OUT_WIDTH      = 6;
  localparam int ACC_WIDTH      = 24;
  localparam int TIMEOUT_CYCLES = 1200;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_dv = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic [OUT_WIDTH-1:0] dds_out;
  logic [1:0]           mode;
  logic                 busy;
  logic                 cmd_ok;
  logic                 cmd_err;

  int checks = 0;
  int errors = 0;

  dds_uart_synth #(
    .OUT_WIDTH      (OUT_WIDTH),
    .ACC_WIDTH      (ACC_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_dv   (rx_dv),
    .rx_byte (rx_byte),
    .dds_out (dds_out),
    .mode    (mode),
    .busy    (busy),
    .cmd_ok  (cmd_ok),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One-cycle strobe; returns at the falling edge right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n;
  logic seen;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_dds_out", 32'(dds_out), 32'h0);
    check("reset_mode",    32'(mode),    32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_pulses",  32'({cmd_ok, cmd_err}), 32'h0);

    // Direct sample: 0xA4 -> top six bits 0x29
    send_byte(8'h03);
    check("direct_busy_mid", 32'(busy), 32'h1);
    send_byte(8'hA4);
    check("direct_cmd_ok", 32'(cmd_ok), 32'h1);
    check("direct_busy_end", 32'(busy), 32'h0);
    tick(1);
    check("direct_dds_out", 32'(dds_out), 32'h29);
    check("direct_ok_1cyc", 32'(cmd_ok), 32'h0);

    // Square, tw = 0x400000, then phase reset: 0,0,63,63,0,0,63,63
    send_byte(8'h02); send_byte(8'h03);
    check("square_mode", 32'(mode), 32'h3);
    send_byte(8'h01); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
    check("freq_cmd_ok", 32'(cmd_ok), 32'h1);
    send_byte(8'h04);
    check("phrst_cmd_ok", 32'(cmd_ok), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("square_s%0d", k), 32'(dds_out), (k % 4 == 3 || k % 4 == 0) ? 32'h3F : 32'h0);
    end

    // Saw, tw = 0x020000: sample k after phase reset = ((k-1)/2) mod 64
    send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h04);
    for (int k = 1; k <= 129; k++) begin
      tick(1);
      if (k == 1)   check("saw_s1",   32'(dds_out), 32'd0);
      if (k == 4)   check("saw_s4",   32'(dds_out), 32'd1);
      if (k == 128) check("saw_s128", 32'(dds_out), 32'd63);
      if (k == 129) check("saw_wrap", 32'(dds_out), 32'd0);
    end

    // Triangle, same tw: P = k-1; P=10 -> 10, P=70 -> ~6 = 57
    send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h04);
    for (int k = 1; k <= 71; k++) begin
      tick(1);
      if (k == 11) check("tri_rise", 32'(dds_out), 32'd10);
      if (k == 71) check("tri_fall", 32'(dds_out), 32'd57);
    end

    // Timeout after a partial SET_FREQ; tw must stay 0x020000
    send_byte(8'h01); send_byte(8'h12);
    check("tmo_busy", 32'(busy), 32'h1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT_CYCLES + 20) begin
      tick(1);
      n++;
      if (cmd_err) seen = 1'b1;
    end
    check("tmo_cmd_err_seen", 32'(seen), 32'h1);
    check("tmo_cycle", 32'(n), 32'(TIMEOUT_CYCLES));
    check("tmo_busy_clear", 32'(busy), 32'h0);
    send_byte(8'h7F);
    check("unknown_cmd_err", 32'(cmd_err), 32'h1);
    check("unknown_busy", 32'(busy), 32'h0);
    send_byte(8'h04);
    tick(11);
    check("tmo_tw_kept", 32'(dds_out), 32'd10);

    // Long strobe counts as one byte
    send_byte(8'h02); send_byte(8'h00);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h03;
    tick(5);
    rx_dv = 1'b0;
    check("long_busy", 32'(busy), 32'h1);
    check("long_no_err", 32'(cmd_err), 32'h0);
    send_byte(8'h80);
    check("long_cmd_ok", 32'(cmd_ok), 32'h1);
    tick(1);
    check("long_direct", 32'(dds_out), 32'h20);

    // Reset mid-frame; next byte is an opcode
    send_byte(8'h01); send_byte(8'h55);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dds_out", 32'(dds_out), 32'h0);
    send_byte(8'h03);
    check("rst_opcode_busy", 32'(busy), 32'h1);
    send_byte(8'hFC);
    tick(1);
    check("rst_direct", 32'(dds_out), 32'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
